// File: rtl/alu_md.sv
// alu_md: execute-stage ALU with an iterative shift-add multiplier, a restoring
// divider and architectural HI/LO registers. Single-cycle ops return a
// registered result one cycle after acceptance. MULT/MULTU/DIV/DIVU take WIDTH
// cycles and hold off issue while they run.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             carryout,
  output logic             div_zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_SLLV  = 5'd10;
  localparam logic [4:0] OP_SRLV  = 5'd11;
  localparam logic [4:0] OP_SRAV  = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam logic [4:0] OP_MTLO  = 5'd20;

  localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHW-1:0]     CNT_LAST = SHW'(WIDTH - 1);

  // The final RUN edge doubles as the DONE step: it commits HI/LO and raises
  // out_valid, so the result appears exactly WIDTH edges after acceptance.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [SHW-1:0]   cnt_r;
  logic [WIDTH-1:0] acc_hi_r;    // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo_r;    // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] opb_r;       // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_r;         // raw in0, needed for the divide-by-zero HI value
  logic             is_div_r;
  logic             res_neg_r;   // negate product / quotient at the end
  logic             rem_neg_r;   // remainder takes dividend sign
  logic             dz_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] out_r;
  logic             ovf_r;
  logic             zero_r;
  logic             cout_r;
  logic             dz_out_r;
  logic             out_valid_r;
  logic             busy_r;

  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] res_s;
  logic             ovf_s;
  logic             cout_s;
  logic             zero_s;
  logic             valid_op_s;
  logic             md_op_s;
  logic             is_div_op_s;
  logic             signed_op_s;
  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;

  logic [WIDTH:0]     msum_s;
  logic [WIDTH-1:0]   mhi_s;
  logic [WIDTH-1:0]   mlo_s;
  logic [WIDTH:0]     shifted_s;
  logic [WIDTH:0]     trial_s;
  logic [WIDTH-1:0]   dhi_s;
  logic [WIDTH-1:0]   dlo_s;
  logic [WIDTH-1:0]   step_hi_s;
  logic [WIDTH-1:0]   step_lo_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;

  assign in_ready_s = !busy_r && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready_s;

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign overflow  = ovf_r;
  assign zero      = zero_r;
  assign carryout  = cout_r;
  assign div_zero  = dz_out_r;
  assign busy      = busy_r;

  // Single-cycle result and flags for the presented operation.
  always_comb begin
    sum_s      = {1'b0, in0} + {1'b0, in1};
    diff_s     = {1'b0, in0} - {1'b0, in1};
    res_s      = ZERO_W;
    ovf_s      = 1'b0;
    cout_s     = 1'b0;
    valid_op_s = 1'b1;
    case (op)
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        ovf_s = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum_s[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_ADDU: begin
        res_s  = sum_s[WIDTH-1:0];
        cout_s = sum_s[WIDTH];
      end
      OP_SUB: begin
        res_s = diff_s[WIDTH-1:0];
        ovf_s = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff_s[WIDTH-1] != in0[WIDTH-1]);
      end
      OP_SUBU: begin
        res_s  = diff_s[WIDTH-1:0];
        cout_s = diff_s[WIDTH];   // borrow: set exactly when in0 < in1 unsigned
      end
      OP_AND:  res_s = in0 & in1;
      OP_OR:   res_s = in0 | in1;
      OP_XOR:  res_s = in0 ^ in1;
      OP_NOR:  res_s = ~(in0 | in1);
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (in0 < in1)};
      OP_SLLV: res_s = in1 << in0[SHW-1:0];
      OP_SRLV: res_s = in1 >> in0[SHW-1:0];
      OP_SRAV: res_s = $signed(in1) >>> in0[SHW-1:0];
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: res_s = ZERO_W;
      OP_MFHI: res_s = hi_r;
      OP_MFLO: res_s = lo_r;
      OP_MTHI, OP_MTLO: res_s = in0;
      default: valid_op_s = 1'b0;   // reserved codes: zero result, all flags clear
    endcase
    zero_s = valid_op_s && (res_s == ZERO_W);
  end

  // Operand decode for the iterative unit: sign handling works on magnitudes.
  always_comb begin
    md_op_s     = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_div_op_s = (op == OP_DIV) || (op == OP_DIVU);
    signed_op_s = (op == OP_MULT) || (op == OP_DIV);
    a_neg_s     = signed_op_s && in0[WIDTH-1];
    b_neg_s     = signed_op_s && in1[WIDTH-1];
    a_mag_s     = a_neg_s ? (~in0 + ONE_W) : in0;
    b_mag_s     = b_neg_s ? (~in1 + ONE_W) : in1;
  end

  // One multiply/divide iteration plus the sign/zero-divisor fix-up applied on
  // the last iteration.
  always_comb begin
    // shift-add: add multiplicand when the current multiplier bit is set
    msum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    mhi_s  = msum_s[WIDTH:1];
    mlo_s  = {msum_s[0], acc_lo_r[WIDTH-1:1]};
    // restoring divide: keep the trial subtraction only when it does not go negative
    shifted_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, opb_r};
    dhi_s     = trial_s[WIDTH] ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
    dlo_s     = {acc_lo_r[WIDTH-2:0], ~trial_s[WIDTH]};
    step_hi_s = is_div_r ? dhi_s : mhi_s;
    step_lo_s = is_div_r ? dlo_s : mlo_s;

    prod_s     = {mhi_s, mlo_s};
    prod_fix_s = res_neg_r ? (~prod_s + ONE_2W) : prod_s;
    quo_s      = res_neg_r ? (~dlo_s + ONE_W) : dlo_s;
    rem_s      = rem_neg_r ? (~dhi_s + ONE_W) : dhi_s;

    if (!is_div_r) begin
      fin_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_fix_s[WIDTH-1:0];
    end else if (dz_r) begin
      fin_hi_s = a_r;
      fin_lo_s = ONES_W;
    end else begin
      fin_hi_s = rem_s;
      fin_lo_s = quo_s;
    end
  end

  // Issue/iterate FSM, HI/LO state and the registered result with its flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {SHW{1'b0}};
      acc_hi_r    <= ZERO_W;
      acc_lo_r    <= ZERO_W;
      opb_r       <= ZERO_W;
      a_r         <= ZERO_W;
      is_div_r    <= 1'b0;
      res_neg_r   <= 1'b0;
      rem_neg_r   <= 1'b0;
      dz_r        <= 1'b0;
      hi_r        <= ZERO_W;
      lo_r        <= ZERO_W;
      out_r       <= ZERO_W;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      cout_r      <= 1'b0;
      dz_out_r    <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (md_op_s) begin
              state_r   <= ST_RUN;
              busy_r    <= 1'b1;
              cnt_r     <= CNT_LAST;
              acc_hi_r  <= ZERO_W;
              acc_lo_r  <= is_div_op_s ? a_mag_s : b_mag_s;
              opb_r     <= is_div_op_s ? b_mag_s : a_mag_s;
              a_r       <= in0;
              is_div_r  <= is_div_op_s;
              res_neg_r <= a_neg_s ^ b_neg_s;
              rem_neg_r <= a_neg_s;
              dz_r      <= is_div_op_s && (in1 == ZERO_W);
            end else begin
              out_r       <= res_s;
              ovf_r       <= ovf_s;
              cout_r      <= cout_s;
              zero_r      <= zero_s;
              dz_out_r    <= 1'b0;
              out_valid_r <= 1'b1;
              if (op == OP_MTHI) begin
                hi_r <= in0;
              end
              if (op == OP_MTLO) begin
                lo_r <= in0;
              end
            end
          end
        end
        ST_RUN: begin
          acc_hi_r <= step_hi_s;
          acc_lo_r <= step_lo_s;
          if (cnt_r == {SHW{1'b0}}) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            hi_r        <= fin_hi_s;
            lo_r        <= fin_lo_s;
            out_r       <= fin_lo_s;
            ovf_r       <= 1'b0;
            cout_r      <= 1'b0;
            zero_r      <= (fin_lo_s == ZERO_W);
            dz_out_r    <= is_div_r && dz_r;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - {{(SHW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed vector table for single-cycle ops plus hand sequences for
// multiply/divide latency, back-pressure and mid-operation reset. A second
// WIDTH=16 instance covers the narrow-datapath cases.
module tb_alu_md;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        sel;          // 0: drive 32-bit instance, 1: drive 16-bit instance
  logic [4:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;

  logic        rdy32, vld32, ovf32, z32, c32, dz32, busy32;
  logic [31:0] out32;
  logic        rdy16, vld16, ovf16, z16, c16, dz16, busy16;
  logic [15:0] out16;

  logic        rdy_m, vld_m, ovf_m, z_m, c_m, dz_m, busy_m;
  logic [31:0] out_m;

  int checks = 0;
  int errors = 0;

  alu_md #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(rdy32),
    .op(op), .in0(in0), .in1(in1), .out_valid(vld32), .out_ready(out_ready),
    .out(out32), .overflow(ovf32), .zero(z32), .carryout(c32),
    .div_zero(dz32), .busy(busy32)
  );

  alu_md #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(rdy16),
    .op(op), .in0(in0[15:0]), .in1(in1[15:0]), .out_valid(vld16), .out_ready(out_ready),
    .out(out16), .overflow(ovf16), .zero(z16), .carryout(c16),
    .div_zero(dz16), .busy(busy16)
  );

  assign rdy_m  = sel ? rdy16  : rdy32;
  assign vld_m  = sel ? vld16  : vld32;
  assign ovf_m  = sel ? ovf16  : ovf32;
  assign z_m    = sel ? z16    : z32;
  assign c_m    = sel ? c16    : c32;
  assign dz_m   = sel ? dz16   : dz32;
  assign busy_m = sel ? busy16 : busy32;
  assign out_m  = sel ? {16'h0000, out16} : out32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        ov;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div, check latency, stall behaviour, LO/flags, then read HI.
  task automatic run_multi(input string nm, input logic s, input logic [4:0] o,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dz, input int lat);
    int cnt;
    logic bad;
    sel = s; op = o; in0 = a; in1 = b; in_valid = 1'b1;
    #1;
    chk({nm, " ready_before"}, {31'd0, rdy_m}, 32'd1);
    tick();
    in_valid = 1'b0;
    in0 = 32'h5A5A_A5A5; in1 = 32'h1234_0000; op = 5'd0;   // must be ignored
    cnt = 0;
    bad = 1'b0;
    while (!vld_m && cnt < lat + 8) begin
      if (rdy_m || !busy_m) bad = 1'b1;
      tick();
      cnt++;
    end
    chk({nm, " stall"},   {31'd0, bad}, 32'd0);
    chk({nm, " latency"}, cnt, lat);
    chk({nm, " lo"},      out_m, exp_lo);
    chk({nm, " dz"},      {31'd0, dz_m}, {31'd0, exp_dz});
    chk({nm, " zero"},    {31'd0, z_m}, {31'd0, (exp_lo == 32'd0)});
    chk({nm, " busy"},    {31'd0, busy_m}, 32'd0);
    op = 5'd17; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({nm, " hi"}, out_m, exp_hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{5'd0,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{5'd1,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{5'd1,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd2,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{5'd2,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{5'd3,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{5'd3,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{5'd5,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{5'd6,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{5'd7,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{5'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{5'd10, 32'h0000_0021, 32'h8000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{5'd11, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{5'd12, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{5'd12, 32'h0000_001F, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{5'd25, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{5'd19, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{5'd20, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{5'd17, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{5'd18, 32'h0000_0055, 32'h0000_0055, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{5'd4,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    op = 5'd0; in0 = 32'd0; in1 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out",   out32, 32'd0);
    chk("rst valid", {31'd0, vld32}, 32'd0);
    chk("rst busy",  {31'd0, busy32}, 32'd0);
    chk("rst flags", {28'd0, ovf32, z32, c32, dz32}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst ready", {31'd0, rdy32}, 32'd1);

    // Single-cycle table, issued back to back with out_ready high.
    for (int i = 0; i < 24; i++) begin
      op = vecs[i].op; in0 = vecs[i].a; in1 = vecs[i].b; in_valid = 1'b1;
      tick();
      chk($sformatf("v%0d valid", i), {31'd0, vld_m}, 32'd1);
      chk($sformatf("v%0d out", i),   out_m, vecs[i].r);
      chk($sformatf("v%0d ovf", i),   {31'd0, ovf_m}, {31'd0, vecs[i].ov});
      chk($sformatf("v%0d zero", i),  {31'd0, z_m},   {31'd0, vecs[i].z});
      chk($sformatf("v%0d cout", i),  {31'd0, c_m},   {31'd0, vecs[i].c});
      chk($sformatf("v%0d dz", i),    {31'd0, dz_m},  32'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("retire valid", {31'd0, vld_m}, 32'd0);

    // Back-pressure: result must hold, then retire alongside the next accept.
    out_ready = 1'b0;
    op = 5'd0; in0 = 32'h7FFF_FFFF; in1 = 32'h0000_0001; in_valid = 1'b1;
    tick();
    op = 5'd0; in0 = 32'd10; in1 = 32'd20;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d out", k),   out_m, 32'h8000_0000);
      chk($sformatf("bp%0d ovf", k),   {31'd0, ovf_m}, 32'd1);
      chk($sformatf("bp%0d valid", k), {31'd0, vld_m}, 32'd1);
      chk($sformatf("bp%0d ready", k), {31'd0, rdy_m}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release ready", {31'd0, rdy_m}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp next out",   out_m, 32'd30);
    chk("bp next ovf",   {31'd0, ovf_m}, 32'd0);
    chk("bp next valid", {31'd0, vld_m}, 32'd1);

    run_multi("mult",   1'b0, 5'd13, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 32);
    run_multi("div",    1'b0, 5'd15, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 32);
    run_multi("divu0",  1'b0, 5'd16, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 32);
    run_multi("divmin", 1'b0, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 32);
    run_multi("multu",  1'b0, 5'd14, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 1'b0, 32);

    // Mid-divide reset: HI/LO preloaded, must read back as zero afterwards.
    op = 5'd19; in0 = 32'h0000_0009; in_valid = 1'b1;
    tick();
    op = 5'd20; in0 = 32'h0000_0005;
    tick();
    chk("mtlo out", out_m, 32'h0000_0005);
    op = 5'd16; in0 = 32'd100; in1 = 32'd3;
    tick();
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort valid", {31'd0, vld_m}, 32'd0);
    chk("abort busy",  {31'd0, busy_m}, 32'd0);
    chk("abort out",   out_m, 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op = 5'd18; in_valid = 1'b1;
    tick();
    chk("abort mflo valid", {31'd0, vld_m}, 32'd1);
    chk("abort mflo", out_m, 32'd0);
    op = 5'd17;
    tick();
    in_valid = 1'b0;
    chk("abort mfhi", out_m, 32'd0);

    // 16-bit instance.
    sel = 1'b1;
    op = 5'd12; in0 = 32'd4; in1 = 32'h0000_8000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("w16 srav valid", {31'd0, vld_m}, 32'd1);
    chk("w16 srav", out_m, 32'h0000_F800);
    run_multi("w16 multu", 1'b1, 5'd14, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0001, 32'h0000_FFFE, 1'b0, 16);
    sel = 1'b0;

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_md.md
# alu_md

Parametrised execute-stage ALU with an integrated iterative multiply/divide unit and architectural HI/LO registers. Sits between the ID/EX pipeline register and EX/MEM. Single-cycle ops return a registered result one cycle after acceptance. MULT/MULTU/DIV/DIVU run for WIDTH cycles behind a valid/ready handshake and stall issue meanwhile.

## Interface
- WIDTH, 32, datapath width; must be a power of two, ≥8
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept; = !busy && (!out_valid || out_ready)
- op  in  5  operation code (see Operation)
- in0  in  WIDTH  operand A (rs; shift amount for shifts; dividend/multiplicand)
- in1  in  WIDTH  operand B (rt; value shifted; divisor/multiplier)
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer takes result
- out  out  WIDTH  result
- overflow, zero, carryout, div_zero  out  1 each  flags, registered with out
- busy  out  1  multi-cycle op in progress

## Operation
- op codes: 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor, 8 slt, 9 sltu, 10 sllv, 11 srlv, 12 srav, 13 mult, 14 multu, 15 div, 16 divu, 17 mfhi, 18 mflo, 19 mthi, 20 mtlo; 21–31 → out=0, all flags 0.
- add/sub: overflow = signed overflow of in0±in1; carryout=0.
- addu: carryout = carry out of bit WIDTH-1; overflow=0. subu: carryout = borrow (in0<in1 unsigned); overflow=0.
- slt/sltu: out = 1/0, signed/unsigned compare.
- Shifts: amount = in0[SHW-1:0]; srav sign-fills; overflow=carryout=0.
- zero = (out==0) for every op incl. multi-cycle results.
- mthi/mtlo: HI/LO ← in0; out = in0. mfhi/mflo: out = HI/LO.
- mult/multu: shift-add, one multiplier bit per cycle; signed handled by magnitude then 2W-bit negate if signs differ. {HI,LO} ← product; out = LO.
- div/divu: restoring, one quotient bit per cycle; signed on magnitudes, quotient negated if signs differ, remainder takes dividend sign. LO ← quotient, HI ← remainder, out = LO.
- Divisor 0: no iteration semantics apply. Result HI=in0, LO=all-ones, div_zero=1, same latency as normal divide. MIN/−1: LO=MIN, HI=0, no flag.
- div_zero = 0 for every other op.
- FSM: IDLE → (accept of op 13–16) → RUN, count = WIDTH-1 down to 0 → DONE writes HI/LO, raises out_valid → IDLE.

## Timing
- Reset (async, rst_n low): out=0, all flags 0, out_valid=0, busy=0, HI=LO=0, FSM=IDLE, counter=0. in_ready=1 once rst_n is high.
- Accept at edge N when in_valid && in_ready. Operands are captured at N; later input changes are ignored.
- Single-cycle ops: out_valid=1 after edge N (latency 1).
- Multi-cycle ops: busy=1 after edge N. WIDTH iteration edges N+1..N+WIDTH. At edge N+WIDTH: HI/LO written, out_valid=1, busy=0. Latency = WIDTH cycles.
- out/flags stay stable while out_valid && !out_ready. in_ready=0 in that state.
- Result retire and new accept may occur at the same edge (full throughput for single-cycle ops).
- mfhi/mflo cannot observe stale HI/LO: in_ready=0 during busy. mthi/mtlo write at acceptance edge.
- rst_n asserted mid-RUN aborts immediately. No partial HI/LO update survives.

## Test plan
- add 0x7FFFFFFF + 0x00000001 → out=0x80000000, overflow=1, zero=0, out_valid exactly 1 cycle after accept; subu 1−2 → 0xFFFFFFFF, carryout=1.
- mult in0=−3 (0xFFFFFFFD), in1=5 → out_valid exactly 32 cycles after accept, in_ready=0 throughout, LO=0xFFFFFFF1; then mfhi → 0xFFFFFFFF.
- div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 → div_zero=1, LO=0xFFFFFFFF, HI=0x00000007; div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Back-pressure: hold out_ready=0 for 5 cycles after a result → out/flags unchanged, in_ready=0. Release → result retires and the next queued add is accepted at the same edge.
- Drop rst_n at cycle 10 of a divu → out_valid=busy=0, HI=LO=0 immediately. After release, mflo → 0 in 1 cycle.
- WIDTH=16 build: srav in1=0x8000, in0=4 → 0xF800; multu 0xFFFF×0xFFFF → HI=0xFFFE, LO=0x0001, latency 16.
